// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester round-robin arbiter/sequencer for a single-port RAM
module ram_port_arbiter #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] din0,
   output logic              ack0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] din1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata1,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t              state;
   state_t              state_nx;
   logic                last_id;
   logic                cmd_id;
   logic                cmd_we;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [DATA_W-1:0]   cmd_din;
   logic [DATA_W-1:0]   rdata_q;
   logic                any_req;
   logic                win_id;

   // Arbitration, next-state and per-state outputs; write enable is gated by rst so a reset in ACCESS never writes
   always_comb begin
      state_nx = state;
      ram_we   = 1'b0;
      ack0     = 1'b0;
      ack1     = 1'b0;
      busy     = 1'b1;
      any_req  = req0 | req1;
      if (req0 & req1)
         win_id = ~last_id;
      else
         win_id = req1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (any_req)
               state_nx = ACCESS;
         end
         ACCESS: begin
            ram_we   = cmd_we & ~rst;
            state_nx = DONE;
         end
         DONE: begin
            ack0     = ~cmd_id;
            ack1     = cmd_id;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Command capture in IDLE, read-data capture and round-robin history update at the end of ACCESS
   always_ff @(posedge clk) begin
      if (rst) begin
         last_id  <= 1'b1;
         cmd_id   <= 1'b0;
         cmd_we   <= 1'b0;
         cmd_addr <= '0;
         cmd_din  <= '0;
         rdata_q  <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            cmd_id   <= win_id;
            cmd_we   <= win_id ? we1   : we0;
            cmd_addr <= win_id ? addr1 : addr0;
            cmd_din  <= win_id ? din1  : din0;
         end
         if (state == ACCESS) begin
            last_id <= cmd_id;
            if (!cmd_we)
               rdata_q <= ram_dout;
         end
      end
   end

   assign ram_addr = cmd_addr;
   assign ram_din  = cmd_din;
   assign rdata0   = rdata_q;
   assign rdata1   = rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, we0, req1, we1;
   logic [2:0] addr0, addr1;
   logic [7:0] din0, din1;
   logic       ack0, ack1, ram_we, busy;
   logic [7:0] rdata0, rdata1, ram_din, ram_dout;
   logic [2:0] ram_addr;

   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .din0(din0), .ack0(ack0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .din1(din1), .ack1(ack1), .rdata1(rdata1),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
      .busy(busy)
   );

   // 8x8 RAM: async read, sync write
   logic [7:0] ram [0:7];
   always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_din;
   assign ram_dout = ram[ram_addr];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // transaction-level model: phase 0 idle, 2 = RAM access cycle, 1 = ack cycle
   int         m_cnt  = 0;
   bit         m_id, m_we, m_last = 1'b1, m_rv;
   bit [2:0]   m_addr;
   bit [7:0]   m_din, m_rd;
   bit [7:0]   mem  [0:7];
   bit         mval [0:7];
   bit         chk_en = 1'b0;

   int         we_n = 0, ack1_n = 0, act_n = 0;
   bit [2:0]   we_addr;
   bit         ack_id [$];
   bit [7:0]   ack_data [$];
   int         ack_cyc [$];

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy",   32'(busy),   32'(m_cnt != 0));
         chk("ram_we", 32'(ram_we), 32'(m_cnt == 2 && m_we && !rst));
         if (m_cnt == 2) chk("ram_addr", 32'(ram_addr), 32'(m_addr));
         if (m_cnt == 2 && m_we) chk("ram_din", 32'(ram_din), 32'(m_din));
         chk("ack0", 32'(ack0), 32'(m_cnt == 1 && !m_id));
         chk("ack1", 32'(ack1), 32'(m_cnt == 1 && m_id));
         if (m_cnt == 1 && !m_we && m_rv)
            chk("rdata", 32'(m_id ? rdata1 : rdata0), 32'(m_rd));
      end
      if (ram_we) begin we_n++; we_addr = ram_addr; end
      if (ack1) ack1_n++;
      if (ack0 | ack1) begin
         ack_id.push_back(ack1);
         ack_data.push_back(ack1 ? rdata1 : rdata0);
         ack_cyc.push_back(cyc);
      end
      if (busy | ram_we | ack0 | ack1) act_n++;
      if (rst) begin
         m_cnt  = 0;
         m_last = 1'b1;
         chk_en = 1'b1;
      end else if (m_cnt == 0) begin
         if (req0 | req1) begin
            m_id   = (req0 & req1) ? !m_last : req1;
            m_we   = m_id ? we1 : we0;
            m_addr = m_id ? addr1 : addr0;
            m_din  = m_id ? din1 : din0;
            m_cnt  = 2;
         end
      end else if (m_cnt == 2) begin
         if (m_we) begin
            mem[m_addr]  = m_din;
            mval[m_addr] = 1'b1;
         end else begin
            m_rd = mem[m_addr];
            m_rv = mval[m_addr];
         end
         m_last = m_id;
         m_cnt  = 1;
      end else begin
         m_cnt = 0;
      end
   end

   task automatic txn(input bit id, input bit we, input logic [2:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output int lat);
      bit got = 1'b0;
      rd  = 8'h00;
      lat = 0;
      @(posedge clk); #1;
      if (id) begin req1 = 1; we1 = we; addr1 = a; din1 = d; end
      else    begin req0 = 1; we0 = we; addr0 = a; din0 = d; end
      while (!got && lat < 10) begin
         @(negedge clk);
         lat++;
         if (id ? ack1 : ack0) begin
            got = 1'b1;
            rd  = id ? rdata1 : rdata0;
         end
      end
      if (!got) chk("txn_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      if (id) req1 = 0; else req0 = 0;
   endtask

   logic [7:0] rd;
   int         lat, base, n0, a0;

   initial begin
      rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; din0 = 0; din1 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",   32'(busy),   32'd0);
      chk("rst_ack",    32'({ack1, ack0}), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_rdata",  32'(rdata0), 32'h00);
      rst = 0;

      // 1: write A5 to addr 3 via requester 0
      n0 = we_n; a0 = ack1_n;
      txn(0, 1, 3'd3, 8'hA5, rd, lat);
      chk("t1_latency", 32'(lat), 32'd3);
      chk("t1_we_count", 32'(we_n - n0), 32'd1);
      chk("t1_we_addr", 32'(we_addr), 32'd3);
      chk("t1_no_ack1", 32'(ack1_n - a0), 32'd0);

      // 2: read addr 3 via requester 1
      n0 = we_n;
      txn(1, 0, 3'd3, 8'h00, rd, lat);
      chk("t2_rdata1", 32'(rd), 32'hA5);
      chk("t2_no_we", 32'(we_n - n0), 32'd0);

      // 3: both requesters held for four transactions
      base = ack_id.size();
      @(posedge clk); #1;
      req0 = 1; we0 = 1; addr0 = 3'd6; din0 = 8'h66;
      req1 = 1; we1 = 0; addr1 = 3'd3; din1 = 8'h00;
      for (int i = 0; i < 40 && ack_id.size() < base + 4; i++) @(posedge clk);
      #1;
      req0 = 0; req1 = 0;
      if (ack_id.size() < base + 4) chk("t3_timeout", 32'(ack_id.size() - base), 32'd4);
      else begin
         for (int i = 0; i < 4; i++) begin
            chk("t3_grant", 32'(ack_id[base + i]), 32'(i % 2));
            if (i > 0) chk("t3_ack_gap", 32'(ack_cyc[base + i] - ack_cyc[base + i - 1]), 32'd3);
         end
         chk("t3_rdata1", 32'(ack_data[base + 1]), 32'hA5);
      end

      // 4: fill all addresses via requester 1, read back via requester 0
      for (int a = 0; a < 8; a++) txn(1, 1, 3'(a), 8'(8'h10 + a), rd, lat);
      for (int a = 0; a < 8; a++) begin
         txn(0, 0, 3'(a), 8'h00, rd, lat);
         chk("t4_readback", 32'(rd), 32'(8'h10 + a));
      end

      // 5: reset during ACCESS of a write drops it
      txn(0, 1, 3'd5, 8'h00, rd, lat);
      n0 = ack_id.size();
      @(posedge clk); #1;
      req0 = 1; we0 = 1; addr0 = 3'd5; din0 = 8'hFF;
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0; req0 = 0;
      repeat (5) @(posedge clk);
      chk("t5_no_ack", 32'(ack_id.size() - n0), 32'd0);
      txn(0, 0, 3'd5, 8'h00, rd, lat);
      chk("t5_readback", 32'(rd), 32'h00);

      // 6: idle with no requests
      a0 = act_n;
      repeat (10) @(posedge clk);
      chk("t6_idle", 32'(act_n - a0), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
